// File: rtl/ftc_tx_sched.sv
// Round-robin burst scheduler feeding the 32->44 bit forbidden-transition encoder.
// Optional build macro FTC_SCHED_PRIO_EN makes requester 0 a fixed-priority source.
module ftc_tx_sched #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       link_ready,
  output logic [DATA_W-1:0]          enc_data,
  output logic                       enc_valid,
  output logic                       enc_last,
  output logic [$clog2(NUM_REQ)-1:0] enc_src,
  output logic                       busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant;
  logic [CNT_W-1:0]   beat_cnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_hit;
  logic               accept;
  logic               burst_end;
  logic [DATA_W-1:0]  grant_word;

  // First valid requester after rr_ptr, wrapping; smallest offset wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand    = '0;
    arb_idx = rr_ptr;
    arb_hit = |req_valid;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      cand = IDX_W'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
      if (req_valid[cand]) arb_idx = cand;
    end
`ifdef FTC_SCHED_PRIO_EN
    if (req_valid[0]) arb_idx = '0;
`endif
  end

  assign grant_word = req_data[32'(grant) * DATA_W +: DATA_W];
  assign accept     = (state == XFER) && req_valid[grant] && link_ready;
  assign burst_end  = req_last[grant] || (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign req_ready  = (state == XFER && link_ready) ? (NUM_REQ'(1) << grant) : '0;
  assign busy       = (state != IDLE);

  // Arbitration / transfer FSM with registered encoder-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      beat_cnt  <= '0;
      enc_data  <= '0;
      enc_valid <= 1'b0;
      enc_last  <= 1'b0;
      enc_src   <= '0;
    end else begin
      enc_valid <= 1'b0;
      enc_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_hit) begin
            grant    <= arb_idx;
            beat_cnt <= '0;
            state    <= XFER;
`ifdef FTC_SCHED_PRIO_EN
            if (!req_valid[0]) rr_ptr <= arb_idx;
`else
            rr_ptr   <= arb_idx;
`endif
          end
        end
        XFER: begin
          if (accept) begin
            enc_data  <= grant_word;
            enc_valid <= 1'b1;
            enc_src   <= grant;
            enc_last  <= burst_end;
            beat_cnt  <= beat_cnt + CNT_W'(1);
            if (burst_end) state <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ftc_tx_sched.sv
// Directed bench for ftc_tx_sched: simple requester models, beat log, hand-derived expectations.
module tb_ftc_tx_sched;

  localparam int NR = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              link_ready;
  logic [DW-1:0]     enc_data;
  logic              enc_valid;
  logic              enc_last;
  logic [1:0]        enc_src;
  logic              busy;

  ftc_tx_sched #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .link_ready(link_ready),
    .enc_data(enc_data), .enc_valid(enc_valid), .enc_last(enc_last),
    .enc_src(enc_src), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          left [NR];
  int          plen [NR];
  int          sent [NR];
  logic [31:0] base [NR];

  logic [1:0]  lg_src  [$];
  logic [31:0] lg_data [$];
  logic        lg_last [$];
  int          lg_cyc  [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = (left[i] != 0);
      req_data[i*DW +: DW]  = base[i] + 32'(sent[i]);
      req_last[i]           = (plen[i] != 0) && (((sent[i] + 1) % (plen[i] == 0 ? 1 : plen[i])) == 0);
    end
  endtask

  task automatic clear_log();
    lg_src.delete(); lg_data.delete(); lg_last.delete(); lg_cyc.delete();
  endtask

  // One clock: sample handshakes at negedge, advance requesters and log #1 after posedge.
  task automatic tick();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++)
      if (acc[i]) begin sent[i]++; left[i]--; end
    drive();
    if (enc_valid) begin
      lg_src.push_back(enc_src); lg_data.push_back(enc_data);
      lg_last.push_back(enc_last); lg_cyc.push_back(cyc);
    end
  endtask

  task automatic run_idle(input string tag, input int max);
    int n;
    n = 0;
    tick();
    while (((left[0] + left[1] + left[2] + left[3]) != 0 || busy) && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_bound"}, 64'(n < max), 1);
  endtask

  task automatic chk_beat(input string tag, input int idx, input int src,
                          input logic [31:0] data, input bit last);
    if (idx < lg_src.size()) begin
      chk({tag, "_src"},  64'(lg_src[idx]), 64'(src));
      chk({tag, "_data"}, 64'(lg_data[idx]), 64'(data));
      chk({tag, "_last"}, 64'(lg_last[idx]), 64'(last));
    end else begin
      chk({tag, "_missing"}, 64'(idx), 64'(lg_src.size()));
    end
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_valid"}, 64'(enc_valid), 0);
    chk({tag, "_data"},  64'(enc_data),  0);
    chk({tag, "_src"},   64'(enc_src),   0);
    chk({tag, "_last"},  64'(enc_last),  0);
    chk({tag, "_busy"},  64'(busy),      0);
    chk({tag, "_ready"}, 64'(req_ready), 0);
  endtask

  // Async assert mid-cycle, check immediately, restart requester word counters.
  task automatic pulse_rst(input string tag);
    #2 rst = 1'b1;
    #1 rst_check(tag);
    for (int i = 0; i < NR; i++) sent[i] = 0;
  endtask

  initial begin
    int          ord  [5];
    int          used [NR];
    logic [31:0] exp_d [7];
    logic [6:0]  pat, exp_v, exp_l;
    int          n;

    rst        = 1'b1;
    link_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin left[i] = 0; plen[i] = 0; sent[i] = 0; base[i] = '0; end
    drive();
    repeat (2) @(posedge clk);
    #1 rst_check("por");
    @(negedge clk) rst = 1'b0;
    tick();

    // T2: requester 2, three-word packet, rr_ptr=0 so 2 wins.
    left[2] = 3; plen[2] = 3; base[2] = 32'hA5A5_0001;
    drive();
    clear_log();
    tick();
    chk("t2_arb_valid", 64'(enc_valid), 0);
    chk("t2_arb_busy",  64'(busy), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_valid", 64'(enc_valid), 1);
      chk("t2_data",  64'(enc_data), 64'(32'hA5A5_0001 + 32'(k)));
      chk("t2_src",   64'(enc_src), 2);
      chk("t2_last",  64'(enc_last), 64'(k == 2));
    end
    chk("t2_gap_busy", 64'(busy), 1);
    tick();
    chk("t2_idle_busy",  64'(busy), 0);
    chk("t2_idle_valid", 64'(enc_valid), 0);
    chk("t2_hold_data",  64'(enc_data), 64'(32'hA5A5_0003));

    // T3: burst cap; rr_ptr=2 so 1 wins, then 2, then 1 twice (last coincides with cap).
    for (int i = 0; i < NR; i++) sent[i] = 0;
    left[1] = 24; plen[1] = 24; base[1] = 32'h1100_0000;
    left[2] = 2;  plen[2] = 2;  base[2] = 32'h2200_0000;
    drive();
    clear_log();
    run_idle("t3", 300);
    chk("t3_count", 64'(lg_src.size()), 26);
    for (int k = 0; k < 8; k++) chk_beat("t3_b0", k, 1, 32'h1100_0000 + 32'(k), k == 7);
    chk_beat("t3_b1", 8, 2, 32'h2200_0000, 1'b0);
    chk_beat("t3_b1", 9, 2, 32'h2200_0001, 1'b1);
    for (int k = 0; k < 8; k++) chk_beat("t3_b2", 10 + k, 1, 32'h1100_0008 + 32'(k), k == 7);
    for (int k = 0; k < 8; k++) chk_beat("t3_b3", 18 + k, 1, 32'h1100_0010 + 32'(k), k == 7);
    if (lg_cyc.size() >= 9) begin
      chk("t3_burst_rate", 64'(lg_cyc[7] - lg_cyc[0]), 7);
      chk("t3_gap",        64'(lg_cyc[8] - lg_cyc[7]), 3);
    end

    // T4: all valid, reset mid-XFER, then continuous rotation from rr_ptr=0.
    for (int i = 0; i < NR; i++) begin
      left[i] = 100; plen[i] = 0; sent[i] = 0; base[i] = 32'(i) << 28; used[i] = 0;
    end
    drive();
    repeat (3) tick();
    pulse_rst("mid");
    @(negedge clk) rst = 1'b0;
    clear_log();
    n = 0;
    while (lg_src.size() < 40 && n < 200) begin tick(); n++; end
    chk("t4_bound", 64'(n < 200), 1);
`ifdef FTC_SCHED_PRIO_EN
    ord = '{0, 0, 0, 0, 0};
`else
    ord = '{1, 2, 3, 0, 1};
`endif
    for (int b = 0; b < 5; b++) begin
      chk_beat("t4_first", 8 * b, ord[b], base[ord[b]] + 32'(used[ord[b]]), 1'b0);
      chk_beat("t4_end", 8 * b + 7, ord[b], base[ord[b]] + 32'(used[ord[b]] + 7), 1'b1);
      used[ord[b]] += 8;
    end
    if (lg_cyc.size() >= 9) chk("t4_gap", 64'(lg_cyc[8] - lg_cyc[7]), 3);

    pulse_rst("abort");
    for (int i = 0; i < NR; i++) left[i] = 0;
    drive();
    @(negedge clk) rst = 1'b0;
    tick();
    chk("abort_busy", 64'(busy), 0);

    // T5: link_ready stalls inside a burst from requester 3.
    left[3] = 4; plen[3] = 4; base[3] = 32'h3300_0000;
    drive();
    pat   = 7'b1110011;
    exp_v = 7'b1110010;
    exp_l = 7'b1000000;
    exp_d = '{32'h0, 32'h3300_0000, 32'h3300_0000, 32'h3300_0000,
              32'h3300_0001, 32'h3300_0002, 32'h3300_0003};
    for (int j = 0; j < 7; j++) begin
      link_ready = pat[j];
      tick();
      chk("t5_valid", 64'(enc_valid), 64'(exp_v[j]));
      chk("t5_data",  64'(enc_data),  64'(exp_d[j]));
      chk("t5_last",  64'(enc_last),  64'(exp_l[j]));
    end
    chk("t5_src",  64'(enc_src), 3);
    chk("t5_sent", 64'(sent[3]), 4);
    link_ready = 1'b1;
    run_idle("t5", 20);

`ifdef FTC_SCHED_PRIO_EN
    // T6: requester 0 wins every arbitration it is valid for.
    for (int i = 0; i < NR; i++) sent[i] = 0;
    left[0] = 3; plen[0] = 1; base[0] = 32'hF000_0000;
    left[3] = 2; plen[3] = 2; base[3] = 32'h3000_0000;
    drive();
    clear_log();
    run_idle("t6", 100);
    chk("t6_count", 64'(lg_src.size()), 5);
    for (int k = 0; k < 3; k++) chk_beat("t6_p0", k, 0, 32'hF000_0000 + 32'(k), 1'b1);
    chk_beat("t6_p3", 3, 3, 32'h3000_0000, 1'b0);
    chk_beat("t6_p3", 4, 3, 32'h3000_0001, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ftc_tx_sched.md
Name: ftc_tx_sched

Overview:
- Transmit scheduler in front of the 32-bit to 44-bit forbidden-transition encoder stage.
- Shares the single encoded link between NUM_REQ requesters using round-robin burst arbitration over valid/ready handshakes.
- Presents one registered 32-bit word per accepted beat to the encoder.
- Holds the bus value when idle, so no spurious transitions reach the crosstalk-coded wires.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, word width fed to the encoder top.
- MAX_BURST, 8, maximum beats per grant before forced re-arbitration (1..255).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_data  input  NUM_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  per-requester last beat of packet.
- req_ready  output  NUM_REQ  per-requester accept; combinational from state, grant and link_ready.
- link_ready  input  1  downstream encoder/link can take a word this cycle.
- enc_data  output  DATA_W  registered word to the encoder data_in.
- enc_valid  output  1  registered; enc_data is a new beat.
- enc_last  output  1  registered; beat closes the burst.
- enc_src  output  clog2(NUM_REQ)  registered source index of the beat.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async assert, synchronous release):
  - state=IDLE, rr_ptr=0, grant=0, beat_cnt=0.
  - enc_data=0, enc_valid=0, enc_last=0, enc_src=0, req_ready=0, busy=0.
- FSM states: IDLE, XFER, GAP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from (rr_ptr+1) mod NUM_REQ upward with wrap.
  - Latch grant index g, set rr_ptr=g, clear beat_cnt, go to XFER.
  - Arbitration takes exactly one cycle.
  - If no req_valid is set, stay in IDLE.
- XFER:
  - req_ready[g]=link_ready; all other req_ready bits are 0.
  - Accept occurs when req_valid[g] & req_ready[g].
  - On accept, the next edge registers: enc_data=word g, enc_valid=1, enc_src=g, enc_last=(req_last[g] | beat_cnt==MAX_BURST-1), and increments beat_cnt.
  - If that enc_last term is 1, go to GAP; otherwise stay in XFER.
  - No accept (valid low or link_ready low): enc_valid=0 next cycle, enc_data and enc_src hold, stay in XFER.
  - There is no timeout; a stalled granted requester keeps the grant.
- GAP:
  - One cycle; all req_ready=0, enc_valid=0, enc_data holds.
  - Then go to IDLE. Minimum spacing between bursts is therefore 2 cycles (GAP + IDLE).
- enc_data changes only on accepted beats. It is never driven to 0 or high-Z outside reset.
- Latency: accepted word appears on enc_data/enc_valid one clock after the accept edge.
- Throughput: 1 beat/cycle inside a burst while valid & link_ready.
- Boundaries:
  - MAX_BURST=1 gives a single-beat burst then GAP.
  - req_last together with the MAX_BURST limit gives a single enc_last.
  - req_valid from a non-granted requester is ignored until the next IDLE.
  - Only requester rr_ptr valid: rr_ptr is re-granted after wrap.
  - Grant index wraps NUM_REQ-1 to 0.
  - rst asserted mid-burst aborts immediately to reset values; a partial burst is not resumed.

Optional Feature:
- Macro FTC_SCHED_PRIO_EN.
- Defined:
  - Requester 0 is a fixed-priority requester. In IDLE, req_valid[0] wins regardless of rr_ptr, and rr_ptr is not updated when 0 is granted.
  - Requesters 1..NUM_REQ-1 round-robin among themselves when req_valid[0]=0.
- Undefined: pure round-robin over all requesters as above.

Test Plan:
- Reset with all inputs active: assert rst mid-XFER → all outputs 0 asynchronously; after release, busy=0 and first grant goes to requester 1 when all valid (rr_ptr=0).
- Requester 2 sends 3 words 0xA5A5_0001..0003, last on the third, link_ready=1 → enc_data sequence 0xA5A50001/2/3 on consecutive cycles, enc_src=2, enc_last=1 on the third, GAP then IDLE.
- Requester 1 holds valid for 20 beats with no last, MAX_BURST=8 → 8 beats with enc_last on the 8th; another valid requester is granted next; requester 1 regains the grant only after the rotation.
- All 4 requesters valid continuously → grant order 1,2,3,0,1; enc_src follows; busy stays high.
- link_ready toggles 1,0,0,1 during a burst → beats accepted only on link_ready=1 cycles; enc_valid=0 and enc_data held through the stall; no word lost or duplicated.
- With FTC_SCHED_PRIO_EN, requesters 0 and 3 valid at every IDLE → requester 0 always granted; requester 3 granted only when req_valid[0]=0.
